neuron_layer_scheduler: RTL and testbench

Time-multiplexes one multiply-accumulate path and one external `activation_function` instance across `NUM_NEURONS` neurons of a fully connected layer. On `start` it latches an input vector. For each neuron it fetches weights and a bias from synchronous memories and accumulates the weighted sum. It then presents sum and bias to the activation unit and returns the activation through a valid/ready output port. It sits between the layer input buffer and the next layer's input collector.

---
 rtl/neuron_layer_scheduler.sv | 161 ++++++++++++++++
 tb/tb_neuron_layer_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_scheduler.sv
// Time-multiplexed scheduler for one fully connected layer: a single MAC path and
// one external activation unit are shared by all neurons, one result per handshake.
module neuron_layer_scheduler #(
    parameter int VOLTAGE_SIZE    = 24,
    parameter int ACTIVATION_SIZE = 54,
    parameter int BIAS_SIZE       = 6,
    parameter int INPUT_SIZE      = 8,
    parameter int WEIGHT_SIZE     = 8,
    parameter int NUM_INPUTS      = 4,
    parameter int NUM_NEURONS     = 4,
    localparam int WA_W  = (NUM_NEURONS * NUM_INPUTS > 1) ? $clog2(NUM_NEURONS * NUM_INPUTS) : 1,
    localparam int NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int ACC_W = VOLTAGE_SIZE - 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [NUM_INPUTS*INPUT_SIZE-1:0] in_data,
    output logic                             busy,
    output logic                             done,
    output logic [WA_W-1:0]                  wt_addr,
    input  logic [WEIGHT_SIZE-1:0]           wt_data,
    output logic [NW-1:0]                    bias_addr,
    input  logic [BIAS_SIZE-1:0]             bias_data,
    output logic [ACC_W-1:0]                 act_sum,
    output logic [BIAS_SIZE-1:0]             act_bias,
    input  logic [ACTIVATION_SIZE-1:0]       act_value,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NW-1:0]                    out_neuron,
    output logic [ACTIVATION_SIZE-1:0]       out_value
);

    localparam int KW     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int PROD_W = INPUT_SIZE + WEIGHT_SIZE;
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_ACT, S_OUT} state_t;

    state_t state, state_nxt;

    logic signed [INPUT_SIZE-1:0] x_lat [NUM_INPUTS];
    logic [KW-1:0]                k;
    logic [NW-1:0]                neuron;
    logic signed [ACC_W-1:0]      acc;
    logic signed [INPUT_SIZE-1:0] x_sel;
    logic signed [PROD_W-1:0]     prod;
    logic signed [SUM_W-1:0]      sum_wide;
    logic signed [ACC_W-1:0]      acc_sat;
    logic                         last_k;
    logic                         last_neuron;

    assign last_k      = (k == KW'(NUM_INPUTS - 1));
    assign last_neuron = (neuron == NW'(NUM_NEURONS - 1));
    assign wt_addr     = WA_W'(int'(neuron) * NUM_INPUTS + int'(k));
    assign bias_addr   = neuron;
    assign out_neuron  = neuron;

    // Weight data lags its address by one cycle, so MAC pairs it with the previous
    // element; DRAIN holds k on the last element and consumes the final weight.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        x_sel = x_lat[0];
        if (state == S_DRAIN) begin
            x_sel = x_lat[k];
        end else if (k != '0) begin
            x_sel = x_lat[k - KW'(1)];
        end
    end

    always_comb begin
        prod     = PROD_W'(x_sel) * PROD_W'($signed(wt_data));
        sum_wide = SUM_W'(acc) + SUM_W'(prod);
        acc_sat  = sum_wide[ACC_W-1:0];
        if (sum_wide > SUM_MAX) begin
            acc_sat = SUM_MAX[ACC_W-1:0];
        end else if (sum_wide < SUM_MIN) begin
            acc_sat = SUM_MIN[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        out_valid = (state == S_OUT);
        case (state)
            S_IDLE:  if (start) state_nxt = S_MAC;
            S_MAC:   if (last_k) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_ACT;
            S_ACT:   state_nxt = S_OUT;
            S_OUT:   if (out_ready) state_nxt = last_neuron ? S_IDLE : S_MAC;
            default: state_nxt = S_IDLE;
        endcase
    end

    // act_sum/act_bias load on entry to ACT and then hold, so act_value has a full
    // cycle to settle before out_value samples it on the ACT->OUT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: x_lat is a small flop array, not a RAM, so it is cleared with the rest of the state.
            for (int i = 0; i < NUM_INPUTS; i++) x_lat[i] <= '0;
            k         <= '0;
            neuron    <= '0;
            acc       <= '0;
            act_sum   <= '0;
            act_bias  <= '0;
            out_value <= '0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only, so every register samples pre-edge values.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            x_lat[i] <= in_data[i*INPUT_SIZE +: INPUT_SIZE];
                        end
                        k      <= '0;
                        neuron <= '0;
                        acc    <= '0;
                    end
                end
                S_MAC: begin
                    if (k != '0) acc <= acc_sat;
                    if (!last_k) k <= k + KW'(1);
                end
                S_DRAIN: begin
                    acc      <= acc_sat;
                    act_sum  <= acc_sat;
                    act_bias <= bias_data;
                end
                S_ACT: begin
                    out_value <= act_value;
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (last_neuron) begin
                            done <= 1'b1;
                        end else begin
                            neuron <= neuron + NW'(1);
                            k      <= '0;
                            acc    <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Scoreboard bench: two schedulers (24-bit and 16-bit voltage) run in lockstep
// against a plain-arithmetic layer model and stub activation units.
module tb_neuron_layer_scheduler;

    localparam int NI = 4;
    localparam int NN = 4;
    localparam int IS = 8;
    localparam int WS = 8;
    localparam int BS = 6;
    localparam int AS = 54;
    localparam int ACCW_A = 23;
    localparam int ACCW_B = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic [NI*IS-1:0] in_data = '0;

    logic busy_a, done_a, out_valid_a;
    logic [3:0] wt_addr_a;
    logic [1:0] bias_addr_a, out_neuron_a;
    logic [WS-1:0] wt_q_a;
    logic [BS-1:0] bias_q_a, act_bias_a;
    logic [ACCW_A-1:0] act_sum_a;
    logic [AS-1:0] act_value_a, out_value_a;

    logic busy_b, done_b, out_valid_b;
    logic [3:0] wt_addr_b;
    logic [1:0] bias_addr_b, out_neuron_b;
    logic [WS-1:0] wt_q_b;
    logic [BS-1:0] bias_q_b, act_bias_b;
    logic [ACCW_B-1:0] act_sum_b;
    logic [AS-1:0] act_value_b, out_value_b;

    neuron_layer_scheduler u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .busy(busy_a), .done(done_a), .wt_addr(wt_addr_a), .wt_data(wt_q_a),
        .bias_addr(bias_addr_a), .bias_data(bias_q_a), .act_sum(act_sum_a),
        .act_bias(act_bias_a), .act_value(act_value_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_neuron(out_neuron_a), .out_value(out_value_a)
    );

    neuron_layer_scheduler #(.VOLTAGE_SIZE(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .busy(busy_b), .done(done_b), .wt_addr(wt_addr_b), .wt_data(wt_q_b),
        .bias_addr(bias_addr_b), .bias_data(bias_q_b), .act_sum(act_sum_b),
        .act_bias(act_bias_b), .act_value(act_value_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_neuron(out_neuron_b), .out_value(out_value_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wmem [NI*NN];
    int bmem [NN];
    int xv [NI];

    always @(posedge clk) begin
        wt_q_a   <= WS'(wmem[wt_addr_a]);
        bias_q_a <= BS'(bmem[bias_addr_a]);
        wt_q_b   <= WS'(wmem[wt_addr_b]);
        bias_q_b <= BS'(bmem[bias_addr_b]);
    end

    // Activation stub: sum + bias + 1000.
    assign act_value_a = AS'(longint'($signed(act_sum_a)) + longint'($signed(act_bias_a)) + 64'sd1000);
    assign act_value_b = AS'(longint'($signed(act_sum_b)) + longint'($signed(act_bias_b)) + 64'sd1000);

    typedef struct {
        int     neuron;
        longint sum_a;
        longint sum_b;
        longint val_a;
        longint val_b;
    } exp_t;

    exp_t   sb [$];
    exp_t   mon_e;
    longint seen_a [$];
    longint seen_b [$];
    longint seen_v [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint got, input longint expv);
        n_checks++;
        if (got != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic longint clamp(input longint v, input int w);
        longint hi = (64'sd1 <<< (w - 1)) - 1;
        longint lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint neuron_sum(input int n, input int w);
        longint acc = 0;
        for (int k = 0; k < NI; k++) begin
            acc = clamp(acc + longint'(xv[k] * wmem[n*NI + k]), w);
        end
        return acc;
    endfunction

    task automatic push_layer();
        exp_t e;
        for (int n = 0; n < NN; n++) begin
            e.neuron = n;
            e.sum_a  = neuron_sum(n, ACCW_A);
            e.sum_b  = neuron_sum(n, ACCW_B);
            e.val_a  = e.sum_a + bmem[n] + 1000;
            e.val_b  = e.sum_b + bmem[n] + 1000;
            sb.push_back(e);
        end
    endtask

    // Monitor: compares every handshake against the scoreboard and checks hold-stability.
    logic          hold_pending = 1'b0;
    logic [AS-1:0] hold_value;
    logic [1:0]    hold_neuron;
    logic [3:0]    hold_addr;
    bit            valid_seen = 1'b0;
    int            valid_cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (hold_pending) begin
                check("hold_valid", longint'(out_valid_a), 1);
                check("hold_value", longint'($signed(out_value_a)), longint'($signed(hold_value)));
                check("hold_neuron", longint'(out_neuron_a), longint'(hold_neuron));
                check("hold_wt_addr", longint'(wt_addr_a), longint'(hold_addr));
            end
            hold_pending = out_valid_a && !out_ready;
            hold_value   = out_value_a;
            hold_neuron  = out_neuron_a;
            hold_addr    = wt_addr_a;
            if (out_valid_a && !valid_seen) begin
                valid_seen = 1'b1;
                valid_cyc  = cyc;
            end
            if (out_valid_a && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_neuron_a", longint'(out_neuron_a), mon_e.neuron);
                    check("act_sum_a", longint'($signed(act_sum_a)), mon_e.sum_a);
                    check("out_value_a", longint'($signed(out_value_a)), mon_e.val_a);
                    check("out_valid_b", longint'(out_valid_b), 1);
                    check("out_neuron_b", longint'(out_neuron_b), mon_e.neuron);
                    check("act_sum_b", longint'($signed(act_sum_b)), mon_e.sum_b);
                    check("out_value_b", longint'($signed(out_value_b)), mon_e.val_b);
                    seen_a.push_back(longint'($signed(act_sum_a)));
                    seen_b.push_back(longint'($signed(act_sum_b)));
                    seen_v.push_back(longint'($signed(out_value_a)));
                end
            end
            if (done_a) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_at_done", longint'(busy_a), 0);
                check("done_b", longint'(done_b), 1);
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    // out_ready driver: 0 = always ready, 1 = random, 2 = hold off neuron 1 for 5 cycles.
    int ready_mode = 0;
    int bp_cnt = 0;

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (out_valid_a && out_neuron_a == 2'd1 && bp_cnt < 5) begin
                    out_ready = 1'b0;
                    bp_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    int start_cyc = 0;

    task automatic load_input();
        for (int k = 0; k < NI; k++) in_data[k*IS +: IS] = IS'(xv[k]);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        valid_seen = 1'b0;
        start      = 1'b1;
        start_cyc  = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_layer(input int mode, input bit poke_start);
        int d0;
        int n;
        ready_mode = mode;
        bp_cnt     = 0;
        load_input();
        seen_a.delete();
        seen_b.delete();
        seen_v.delete();
        push_layer();
        d0 = done_cnt;
        pulse_start();
        if (poke_start) begin
            repeat (3) @(posedge clk);
            #1;
            in_data = ~in_data;
            start   = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) check("layer_timeout", 0, 1);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt - d0, 1);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic randomize_layer();
        for (int k = 0; k < NI; k++) xv[k] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < NI*NN; i++) wmem[i] = int'($urandom_range(0, 255)) - 128;
        for (int n = 0; n < NN; n++) bmem[n] = int'($urandom_range(0, 63)) - 32;
    endtask

    initial begin
        int d0;
        int n;
        longint full_exp [NN];
        full_exp = '{-10, 0, 10, 20};

        for (int i = 0; i < NI*NN; i++) wmem[i] = 0;
        for (int i = 0; i < NN; i++) bmem[i] = 0;
        for (int i = 0; i < NI; i++) xv[i] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy_a), 0);
        check("rst_done", longint'(done_a), 0);
        check("rst_out_valid", longint'(out_valid_a), 0);
        check("rst_wt_addr", longint'(wt_addr_a), 0);
        check("rst_bias_addr", longint'(bias_addr_a), 0);
        check("rst_act_sum", longint'(act_sum_a), 0);
        check("rst_act_bias", longint'(act_bias_a), 0);
        check("rst_out_neuron", longint'(out_neuron_a), 0);
        check("rst_out_value", longint'(out_value_a), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Basic: x=[1,2,3,4], neuron 0 weights 1, bias 2
        xv = '{1, 2, 3, 4};
        for (int k = 0; k < NI; k++) wmem[k] = 1;
        bmem[0] = 2;
        run_layer(0, 1'b0);
        check("basic_latency", valid_cyc - start_cyc, 7);
        check("basic_act_sum", (seen_a.size() > 0) ? seen_a[0] : -1, 10);
        check("basic_out_value", (seen_v.size() > 0) ? seen_v[0] : -1, 1012);

        // Full layer: neuron n weights n-1, bias 0
        for (int nn = 0; nn < NN; nn++) begin
            bmem[nn] = 0;
            for (int k = 0; k < NI; k++) wmem[nn*NI + k] = nn - 1;
        end
        run_layer(0, 1'b0);
        check("full_done_time", done_cyc - start_cyc, 29);
        for (int i = 0; i < NN; i++) begin
            check("full_act_sum", (seen_a.size() > i) ? seen_a[i] : -999, full_exp[i]);
        end

        // Backpressure on neuron 1
        randomize_layer();
        run_layer(2, 1'b0);
        check("bp_cycles_held", bp_cnt, 5);

        // Saturation (16-bit voltage instance clamps to 15-bit range)
        for (int k = 0; k < NI; k++) xv[k] = 127;
        for (int i = 0; i < NI*NN; i++) wmem[i] = 127;
        for (int i = 0; i < NN; i++) bmem[i] = 0;
        run_layer(0, 1'b0);
        check("sat_pos_b", (seen_b.size() > 0) ? seen_b[0] : 0, 16383);
        check("sat_pos_a", (seen_a.size() > 0) ? seen_a[0] : 0, 64516);
        for (int k = 0; k < NI; k++) xv[k] = -128;
        run_layer(0, 1'b0);
        check("sat_neg_b", (seen_b.size() > 0) ? seen_b[0] : 0, -16384);
        check("sat_neg_a", (seen_a.size() > 0) ? seen_a[0] : 0, -65024);

        // Random layers with random backpressure; some poke start while busy
        for (int r = 0; r < 6; r++) begin
            randomize_layer();
            run_layer(1, (r % 2) == 1);
        end

        // Reset during MAC of neuron 2
        randomize_layer();
        ready_mode = 0;
        load_input();
        push_layer();
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (!(busy_a && !out_valid_a && out_neuron_a == 2'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_neuron2_mac", longint'(out_neuron_a == 2'd2 && busy_a && !out_valid_a), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", longint'(busy_a), 0);
        check("mid_rst_out_valid", longint'(out_valid_a), 0);
        check("mid_rst_wt_addr", longint'(wt_addr_a), 0);
        check("mid_rst_bias_addr", longint'(bias_addr_a), 0);
        check("mid_rst_act_sum", longint'(act_sum_a), 0);
        check("mid_rst_act_bias", longint'(act_bias_a), 0);
        check("mid_rst_out_neuron", longint'(out_neuron_a), 0);
        check("mid_rst_out_value", longint'(out_value_a), 0);
        check("mid_rst_done", longint'(done_a), 0);
        sb.delete();
        repeat (5) @(negedge clk);
        check("no_done_after_reset", done_cnt - d0, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        randomize_layer();
        run_layer(0, 1'b0);
        check("restart_latency", valid_cyc - start_cyc, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
